// File: rtl/mips_cpu_muldiv_seq.sv
// mips_cpu_muldiv_seq: iterative multiply/divide unit owning the MIPS HI/LO pair.
// Multiply is shift-add and divide is restoring; each resolves one bit per cycle.
// Optional feature macro: MIPS_CPU_MULDIV_FAST_MULT_EN.
// When it is defined, MULT/MULTU use a single-cycle multiplier and skip FIX.
module mips_cpu_muldiv_seq (
  input  logic        clk,
  input  logic        reset,     // asynchronous, active low
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;      // mult: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic [31:0] opnd_q, opnd_d;    // |multiplicand| or |divisor|
  logic [31:0] araw_q, araw_d;    // unmodified dividend for divide-by-zero
  logic        is_div_q, is_div_d;
  logic        neg_q, neg_d;      // product / quotient negative
  logic        rneg_q, rneg_d;    // remainder negative
  logic        div0_q, div0_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        done_q, done_d, dz_q, dz_d;

  // Operand conditioning: signed ops work on magnitudes.
  logic        op_signed;
  logic [31:0] a_abs, b_abs;
  assign op_signed = ~op[0];
  assign a_abs = (op_signed && a[31]) ? (~a + 32'd1) : a;
  assign b_abs = (op_signed && b[31]) ? (~b + 32'd1) : b;

  // One shift-add multiply step.
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
  assign mul_next = {mul_sum, acc_q[31:1]};

  // One restoring divide step.
  logic [32:0] rem_sh, rem_sub;
  logic        div_ge;
  logic [63:0] div_next;
  assign rem_sh   = acc_q[63:31];
  assign div_ge   = rem_sh >= {1'b0, opnd_q};
  assign rem_sub  = rem_sh - {1'b0, opnd_q};
  assign div_next = {(div_ge ? rem_sub[31:0] : rem_sh[31:0]), acc_q[30:0], div_ge};

  // Sign-corrected results.
  logic [63:0] prod_fix;
  logic [31:0] quot_fix, rem_fix;
  assign prod_fix = neg_q  ? (~acc_q + 64'd1) : acc_q;
  assign quot_fix = neg_q  ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
  assign rem_fix  = rneg_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

`ifdef MIPS_CPU_MULDIV_FAST_MULT_EN
  logic [63:0] fast_prod, fast_fix;
  assign fast_prod = {32'd0, opnd_q} * {32'd0, acc_q[31:0]};
  assign fast_fix  = neg_q ? (~fast_prod + 64'd1) : fast_prod;
`endif

  // State register plus datapath and HI/LO registers; reset aborts everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      acc_q    <= 64'd0;
      opnd_q   <= 32'd0;
      araw_q   <= 32'd0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      araw_q   <= araw_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      div0_q   <= div0_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    araw_d   = araw_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    div0_d   = div0_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dz_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            3'b000, 3'b001, 3'b010, 3'b011: begin
              is_div_d = op[1];
              acc_d    = {32'd0, (op[1] ? a_abs : b_abs)};
              opnd_d   = op[1] ? b_abs : a_abs;
              araw_d   = a;
              neg_d    = op_signed && (a[31] ^ b[31]);
              rneg_d   = op_signed && a[31];
              div0_d   = op[1] && (b == 32'd0);
              cnt_d    = 5'd31;
              state_d  = CALC;
            end
            3'b100: begin
              hi_d   = a;
              done_d = 1'b1;
            end
            3'b101: begin
              lo_d   = a;
              done_d = 1'b1;
            end
            default: ; // MFHI/MFLO read hi/lo directly
          endcase
        end
      end
      CALC: begin
`ifdef MIPS_CPU_MULDIV_FAST_MULT_EN
        if (!is_div_q) begin
          {hi_d, lo_d} = fast_fix;
          done_d       = 1'b1;
          cnt_d        = 5'd0;
          state_d      = IDLE;
        end else begin
          acc_d = div_next;
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd0) state_d = FIX;
        end
`else
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) state_d = FIX;
`endif
      end
      FIX: begin
        if (!is_div_q) begin
          {hi_d, lo_d} = prod_fix;
        end else if (div0_q) begin
          lo_d = 32'hFFFF_FFFF;
          hi_d = araw_q;
        end else begin
          lo_d = quot_fix;
          hi_d = rem_fix;
        end
        done_d  = 1'b1;
        dz_d    = div0_q;
        cnt_d   = 5'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
